// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states and counter sizing for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: gate-level one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder around one full_adder; SERIAL_ADDSUB_EN adds sub/ovf
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic [CW-1:0] cnt;
  logic carry, carry_init, fa_b, fa_s, fa_c, last, accept;
  assign accept = (state == IDLE) && start;
  assign last   = cnt == CW'(WIDTH - 1);
  assign s_next = WIDTH'({fa_s, s_sr} >> 1);
`ifdef SERIAL_ADDSUB_EN
  logic sub_r;
  assign fa_b       = b_sr[0] ^ sub_r;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign fa_b       = b_sr[0];
  assign carry_init = cin;
`endif

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (fa_b),
    .cin (carry),
    .sum (fa_s),
    .cout(fa_c)
  );

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  // next state and status outputs; DONE and any stray encoding fall back to IDLE
  always_comb begin
    state_n = (state == RUN) ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    busy    = state != IDLE;
    done    = state == DONE;
  end

  // operand capture, serial shifting, and result registration on the last bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= carry_init;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_next;
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= s_next;
        cout <= fa_c;
      end
    end

`ifdef SERIAL_ADDSUB_EN
  // subtract mode capture and signed overflow from carries into/out of the top bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sub_r <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      sub_r <= sub;
    end else if (state == RUN && last) begin
      ovf <= carry ^ fa_c;
    end
`endif
endmodule
